// File: rtl/camera_frame_writer.sv
// Captures a raster camera stream and writes each pixel into a double-buffered SDRAM frame store.
// The display offset flips to the freshly written buffer only after a frame completes cleanly.
module camera_frame_writer #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter logic [24:0] BUF0_BASE = 25'd0,
    parameter logic [24:0] BUF1_BASE = 25'd524288
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        cam_fval,
    input  logic        cam_lval,
    input  logic [9:0]  cam_data,
    output logic        portC_write,
    output logic [24:0] portC_addr,
    output logic [9:0]  portC_din,
    output logic [24:0] disp_offset,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  frames_dropped
);

    localparam logic [10:0] COL_MAX = 11'd2047;
    localparam logic [9:0]  ROW_MAX = 10'd1023;
    localparam logic [10:0] H_COL   = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ROW   = 10'(V_ACTIVE);
    localparam logic [24:0] H_STEP  = 25'(H_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPTURE
    } state_t;

    state_t      state;
    logic        fval_d;
    logic        lval_d;
    logic        fval_low_seen;
    logic [10:0] col;
    logic [9:0]  row;
    logic [24:0] line_base;
    logic        bad;
    logic        buf_sel;

    logic        pixel_ok;
    logic        line_end;
    logic        frame_end;
    logic        in_window;
    logic [10:0] col_inc;
    logic [9:0]  row_inc;
    logic [9:0]  frame_row;
    logic        frame_bad;
    logic [24:0] back_base;

    // A frame-valid fall while line-valid was high also closes the current line.
    always_comb begin
        pixel_ok  = cam_fval & cam_lval;
        line_end  = lval_d & (~cam_lval | ~cam_fval);
        frame_end = fval_d & ~cam_fval;
        in_window = (col < H_COL) && (row < V_ROW);
        col_inc   = (col == COL_MAX) ? col : col + 11'd1;
        row_inc   = (row == ROW_MAX) ? row : row + 10'd1;
        frame_row = line_end ? row_inc : row;
        frame_bad = bad | (line_end & (col != H_COL)) | (frame_row != V_ROW);
        back_base = buf_sel ? BUF0_BASE : BUF1_BASE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            fval_d         <= 1'b0;
            lval_d         <= 1'b0;
            fval_low_seen  <= 1'b0;
            col            <= '0;
            row            <= '0;
            line_base      <= '0;
            bad            <= 1'b0;
            buf_sel        <= 1'b0;
            portC_write    <= 1'b0;
            portC_addr     <= '0;
            portC_din      <= '0;
            disp_offset    <= BUF0_BASE;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
            frames_dropped <= '0;
        end else begin
            fval_d      <= cam_fval;
            lval_d      <= cam_lval;
            portC_write <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;

            case (state)
                IDLE: begin
                    fval_low_seen <= 1'b0;
                    if (capture_en) begin
                        state <= SYNC;
                    end
                end

                // Only a rise that follows a sampled low starts a frame, so a frame is never joined mid-way.
                SYNC: begin
                    if (!capture_en) begin
                        fval_low_seen <= 1'b0;
                        state         <= IDLE;
                    end else if (!cam_fval) begin
                        fval_low_seen <= 1'b1;
                    end else if (fval_low_seen) begin
                        fval_low_seen <= 1'b0;
                        row           <= '0;
                        line_base     <= back_base;
                        bad           <= 1'b0;
                        state         <= CAPTURE;
                        if (cam_lval && H_ACTIVE > 0 && V_ACTIVE > 0) begin
                            portC_write <= 1'b1;
                            portC_addr  <= back_base;
                            portC_din   <= cam_data;
                            col         <= 11'd1;
                        end else begin
                            col <= '0;
                        end
                    end
                end

                CAPTURE: begin
                    if (pixel_ok) begin
                        if (in_window) begin
                            portC_write <= 1'b1;
                            portC_addr  <= line_base + {14'd0, col};
                            portC_din   <= cam_data;
                        end else begin
                            bad <= 1'b1;
                        end
                        col <= col_inc;
                    end

                    if (line_end) begin
                        if (col != H_COL) begin
                            bad <= 1'b1;
                        end
                        row       <= row_inc;
                        line_base <= line_base + H_STEP;
                        col       <= '0;
                    end

                    if (frame_end) begin
                        if (frame_bad) begin
                            frame_err <= 1'b1;
                            if (frames_dropped != 8'hFF) begin
                                frames_dropped <= frames_dropped + 8'd1;
                            end
                        end else begin
                            frame_done  <= 1'b1;
                            disp_offset <= back_base;
                            buf_sel     <= ~buf_sel;
                        end
                        state <= capture_en ? SYNC : IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Randomized scoreboard bench for camera_frame_writer on a reduced frame geometry.
// Expected writes and frame outcomes come from a line-by-line model of the frame buffer layout.
module tb_camera_frame_writer;

    localparam int          H    = 16;
    localparam int          V    = 12;
    localparam logic [24:0] BUF0 = 25'd0;
    localparam logic [24:0] BUF1 = 25'd524288;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        capture_en;
    logic        cam_fval;
    logic        cam_lval;
    logic [9:0]  cam_data;
    logic        portC_write;
    logic [24:0] portC_addr;
    logic [9:0]  portC_din;
    logic [24:0] disp_offset;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  frames_dropped;

    typedef struct packed {
        logic [24:0] addr;
        logic [9:0]  data;
    } wr_t;

    typedef struct packed {
        logic        good;
        logic [24:0] disp;
        logic [7:0]  dropped;
    } ev_t;

    wr_t         wr_q[$];
    ev_t         ev_q[$];
    int          line_len[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [24:0] model_disp;
    int          model_dropped;

    camera_frame_writer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .BUF0_BASE(BUF0),
        .BUF1_BASE(BUF1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .capture_en    (capture_en),
        .cam_fval      (cam_fval),
        .cam_lval      (cam_lval),
        .cam_data      (cam_data),
        .portC_write   (portC_write),
        .portC_addr    (portC_addr),
        .portC_din     (portC_din),
        .disp_offset   (disp_offset),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_write", {31'd0, portC_write}, 32'd0);
        checkOutput("rst_addr", {7'd0, portC_addr}, 32'd0);
        checkOutput("rst_din", {22'd0, portC_din}, 32'd0);
        checkOutput("rst_disp", {7'd0, disp_offset}, {7'd0, BUF0});
        checkOutput("rst_done", {31'd0, frame_done}, 32'd0);
        checkOutput("rst_err", {31'd0, frame_err}, 32'd0);
        checkOutput("rst_dropped", {24'd0, frames_dropped}, 32'd0);
    endtask

    // Monitor: every strobe or pulse the DUT presents must match the head of its queue.
    always @(negedge clk) begin
        wr_t w;
        ev_t e;
        if (portC_write === 1'b1) begin
            if (wr_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0d, expected no write", portC_addr, portC_din);
            end else begin
                w = wr_q.pop_front();
                checkOutput("write_addr", {7'd0, portC_addr}, {7'd0, w.addr});
                checkOutput("write_data", {22'd0, portC_din}, {22'd0, w.data});
            end
        end
        if (frame_done === 1'b1 || frame_err === 1'b1) begin
            if (ev_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_frame_pulse: got done %0d err %0d, expected none", frame_done, frame_err);
            end else begin
                e = ev_q.pop_front();
                checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e.good});
                checkOutput("frame_err", {31'd0, frame_err}, {31'd0, ~e.good});
                checkOutput("disp_offset", {7'd0, disp_offset}, {7'd0, e.disp});
                checkOutput("frames_dropped", {24'd0, frames_dropped}, {24'd0, e.dropped});
            end
        end
    end

    task automatic setNominal(input int lines);
        line_len.delete();
        for (int i = 0; i < lines; i++) begin
            line_len.push_back(H);
        end
    endtask

    // Drives one frame from line_len and records what the frame buffer should receive.
    task automatic applyStimulus(input bit captured, input bit simul_end, input int reset_line,
                                 input int en_on_line, input int en_off_line);
        logic [24:0] back;
        logic [9:0]  d;
        wr_t         w;
        ev_t         e;
        bit          live;
        bit          bad;
        int          nlines;
        back   = (model_disp == BUF0) ? BUF1 : BUF0;
        live   = captured;
        bad    = 1'b0;
        nlines = line_len.size();
        cam_fval = 1'b1;
        cam_lval = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        for (int r = 0; r < nlines; r++) begin
            if (r == en_on_line) capture_en = 1'b1;
            if (r == en_off_line) capture_en = 1'b0;
            if (r == reset_line) begin
                rst_n = 1'b0;
                #1;
                checkResetValues();
                live          = 1'b0;
                model_disp    = BUF0;
                model_dropped = 0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            for (int c = 0; c < line_len[r]; c++) begin
                d        = 10'($urandom);
                cam_lval = 1'b1;
                cam_data = d;
                if (live && c < H && r < V) begin
                    w.addr = back + 25'(r * H + c);
                    w.data = d;
                    wr_q.push_back(w);
                end
                tick();
            end
            if (line_len[r] != H) bad = 1'b1;
            if (r == nlines - 1 && simul_end) begin
                cam_lval = 1'b0;
                cam_fval = 1'b0;
            end else begin
                cam_lval = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                if (r == nlines - 1) cam_fval = 1'b0;
            end
        end
        if (nlines != V) bad = 1'b1;
        if (live) begin
            if (!bad) begin
                model_disp = back;
            end else if (model_dropped < 255) begin
                model_dropped++;
            end
            e.good    = ~bad;
            e.disp    = model_disp;
            e.dropped = 8'(model_dropped);
            ev_q.push_back(e);
        end
        repeat ($urandom_range(4, 7)) tick();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        capture_en    = 1'b0;
        cam_fval      = 1'b0;
        cam_lval      = 1'b0;
        cam_data      = '0;
        model_disp    = BUF0;
        model_dropped = 0;
        #2 rst_n = 1'b0;
        #10;
        checkResetValues();
        tick();
        rst_n = 1'b1;
        tick();
        capture_en = 1'b1;
        repeat (3) tick();

        // Two nominal frames ping-pong between buffer 1 and buffer 0.
        setNominal(V);
        applyStimulus(1'b1, 1'b0, -1, -1, -1);
        setNominal(V);
        applyStimulus(1'b1, 1'b0, -1, -1, -1);

        // Long and short lines make a bad frame; the following good one reuses the back buffer.
        setNominal(V);
        line_len[3] = H + 10;
        line_len[7] = H - 10;
        applyStimulus(1'b1, 1'b0, -1, -1, -1);
        setNominal(V);
        applyStimulus(1'b1, 1'b0, -1, -1, -1);

        // Enable raised mid-frame: that frame is skipped, the next one is captured.
        capture_en = 1'b0;
        repeat (3) tick();
        setNominal(V);
        applyStimulus(1'b0, 1'b0, -1, 2, -1);
        setNominal(V);
        applyStimulus(1'b1, 1'b0, -1, -1, 5);
        setNominal(V);
        applyStimulus(1'b0, 1'b0, -1, -1, -1);
        capture_en = 1'b1;
        repeat (3) tick();

        // Line and frame valid fall together on the last line.
        setNominal(V);
        applyStimulus(1'b1, 1'b1, -1, -1, -1);

        // Reset mid-frame, then capture resumes into buffer 1.
        setNominal(V);
        applyStimulus(1'b1, 1'b0, V / 2, -1, -1);
        setNominal(V);
        applyStimulus(1'b1, 1'b0, -1, -1, -1);

        // Wrong line counts: too many lines, then too few.
        setNominal(V + int'($urandom_range(1, 2)));
        applyStimulus(1'b1, 1'b0, -1, -1, -1);
        setNominal(V - int'($urandom_range(1, 2)));
        applyStimulus(1'b1, 1'b1, -1, -1, -1);
        setNominal(V);
        applyStimulus(1'b1, 1'b0, -1, -1, -1);

        repeat (10) tick();
        checkOutput("writes_outstanding", wr_q.size(), 32'd0);
        checkOutput("frames_outstanding", ev_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
